// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Types and constants for the pipeline hazard controller.
//   pipe_ctrl_state_t : sequencer states (RUN, MD_WAIT, MD_DONE)
//   pipe_ctrl_t       : the six pipeline-register control signals as one bundle
//   PC_RESET_CTRL     : control value during reset. The PC and IF/ID are enabled,
//                       and every bubble, hold and flush is off.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    MD_DONE = 2'd2
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_hold;
    logic ex_mem_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t PC_RESET_CTRL = '{
    pc_write:      1'b1,
    if_id_write:   1'b1,
    if_id_flush:   1'b0,
    id_ex_bubble:  1'b0,
    id_ex_hold:    1'b0,
    ex_mem_bubble: 1'b0
  };

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
//   Combinational load-use hazard compare between the instruction in ID and a
//   load in EX. A load to x0 never creates a dependency.
//   Ports:
//     id_rs1, id_rs2            in  source registers of the ID instruction
//     id_uses_rs1, id_uses_rs2  in  the ID instruction really reads that source
//     ex_mem_read               in  the EX instruction is a load
//     ex_rd                     in  destination register of the EX instruction
//     lu                        out load-use hit
module load_use_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       lu
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1 = id_uses_rs1 && (id_rs1 == ex_rd);
  assign hit_rs2 = id_uses_rs2 && (id_rs2 == ex_rd);
  assign lu      = ex_mem_read && (ex_rd != 5'd0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall and flush sequencer for the 5-stage pipeline. It handles three
//   cases:
//     - a load-use hazard stalls the front end for one cycle and inserts a bubble;
//     - a taken branch flushes IF/ID and bubbles ID/EX;
//     - a multi-cycle mul/div freezes the front end until md_done arrives or
//       MD_TIMEOUT expires.
//   Outputs are combinational from the state and the inputs. While reset is high
//   they take the PC_RESET_CTRL values.
//   Parameters:
//     MD_TIMEOUT (>=2) : maximum cycles in MD_WAIT before forced release
//     CNT_W            : width of the wait counter; must hold MD_TIMEOUT
//   Optional feature, macro PIPE_HAZARD_PERF_EN:
//     perf_stall_cycles : counts cycles with pc_write=0
//     perf_flushes      : counts cycles with if_id_flush=1
//     Both are 32 bits wide and wrap.
//   Ports:
//     clock, reset (synchronous, active-high)
//     id_rs1/id_rs2, id_uses_rs1/id_uses_rs2      ID source operands
//     ex_mem_read, ex_rd                          load in EX
//     ex_branch_taken, ex_md_op, md_done          EX resolution and mul/div status
//     md_start                                    1-cycle start pulse to mul/div
//     pc_write, if_id_write, if_id_flush          front-end control
//     id_ex_bubble, id_ex_hold, ex_mem_bubble     back-end control
//     md_timeout                                  sticky timeout error
//     dbg_state                                   current sequencer state
//   md_start is a single-cycle pulse with no handshake. md_done is accepted
//   only in MD_WAIT and is ignored in all other states.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_md_op,
  input  logic             md_done,
  output logic             md_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             ex_mem_bubble,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_flushes,
`endif
  output logic             md_timeout,
  output pipe_ctrl_state_t dbg_state
);

  pipe_ctrl_state_t state;
  logic [CNT_W-1:0] md_cnt;
  logic             md_timeout_q;
  logic             lu;
  pipe_ctrl_t       ctrl;
  logic             md_start_c;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .lu          (lu)
  );

  // Start from the free-running value. Each state then overrides only the
  // bits it needs to change.
  always_comb begin
    ctrl       = PC_RESET_CTRL;
    md_start_c = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (ex_md_op) begin
            md_start_c         = 1'b1;
            ctrl.pc_write      = 1'b0;
            ctrl.if_id_write   = 1'b0;
            ctrl.id_ex_hold    = 1'b1;
            ctrl.ex_mem_bubble = 1'b1;
          end else if (ex_branch_taken) begin
            // The ID instruction is squashed, so any load-use hit is irrelevant.
            ctrl.if_id_flush   = 1'b1;
            ctrl.id_ex_bubble  = 1'b1;
          end else if (lu) begin
            ctrl.pc_write      = 1'b0;
            ctrl.if_id_write   = 1'b0;
            ctrl.id_ex_bubble  = 1'b1;
          end
        end
        MD_WAIT: begin
          ctrl.pc_write      = 1'b0;
          ctrl.if_id_write   = 1'b0;
          ctrl.id_ex_hold    = 1'b1;
          ctrl.ex_mem_bubble = 1'b1;
        end
        MD_DONE: begin
          // The mul/div result passes into EX/MEM this cycle. ex_md_op is
          // still high for the same op and must not restart the unit.
          if (lu) begin
            ctrl.pc_write      = 1'b0;
            ctrl.if_id_write   = 1'b0;
            ctrl.id_ex_bubble  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      md_cnt       <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ex_md_op) begin
            state  <= MD_WAIT;
            md_cnt <= '0;
          end
        end
        MD_WAIT: begin
          md_cnt <= md_cnt + 1'b1;
          // If md_done and the final count happen together, md_done wins and
          // no error is flagged.
          if (md_done) begin
            state <= MD_DONE;
          end else if (md_cnt == CNT_W'(MD_TIMEOUT - 1)) begin
            md_timeout_q <= 1'b1;
            state        <= MD_DONE;
          end
        end
        MD_DONE: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if (!ctrl.pc_write)   perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (ctrl.if_id_flush) perf_flushes      <= perf_flushes + 32'd1;
    end
  end
`endif

  assign md_start      = md_start_c;
  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign id_ex_hold    = ctrl.id_ex_hold;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign md_timeout    = md_timeout_q && !reset;
  assign dbg_state     = state;

  // A branch and a mul/div op can never be in EX together.
  a_no_branch_md : assert property (@(posedge clock) disable iff (reset)
    !(ex_branch_taken && ex_md_op));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  import cpu_pkg::*;

  localparam int TO = 64;
  localparam int W  = 10;

  // Output bit order: md_start, pc_write, if_id_write, if_id_flush,
  //                   id_ex_bubble, id_ex_hold, ex_mem_bubble, md_timeout
  localparam logic [7:0] C_FREE   = 8'b0110_0000;
  localparam logic [7:0] C_LU     = 8'b0000_1000;
  localparam logic [7:0] C_BRANCH = 8'b0111_1000;
  localparam logic [7:0] C_MDSTRT = 8'b1000_0110;
  localparam logic [7:0] C_FREEZE = 8'b0000_0110;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
  logic       ex_branch_taken, ex_md_op, md_done;
  logic       md_start, pc_write, if_id_write, if_id_flush;
  logic       id_ex_bubble, id_ex_hold, ex_mem_bubble, md_timeout;
  pipe_ctrl_state_t dbg_state;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
  int          exp_stalls, exp_flushes;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  pipeline_hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(7)) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_md_op(ex_md_op), .md_done(md_done),
    .md_start(md_start), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble),
`ifdef PIPE_HAZARD_PERF_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes),
`endif
    .md_timeout(md_timeout), .dbg_state(dbg_state)
  );

  // Clock and reset.
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Driver: put all inputs at their idle values.
  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    ex_branch_taken = 1'b0; ex_md_op = 1'b0; md_done = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2;
  endtask

  // Scoreboard step. The expected word {state, controls} is pushed when the
  // cycle's stimulus is set, then popped and compared at the negedge.
  task automatic expect_cycle(input string tag, input pipe_ctrl_state_t st, input logic [7:0] c);
    logic [W-1:0] got;
    exp_q.push_back({st, c});
`ifdef PIPE_HAZARD_PERF_EN
    if (reset) begin
      exp_stalls = 0; exp_flushes = 0;
    end else begin
      if (!c[6]) exp_stalls++;
      if (c[4])  exp_flushes++;
    end
`endif
    @(negedge clock);
    got = {dbg_state, md_start, pc_write, if_id_write, if_id_flush,
           id_ex_bubble, id_ex_hold, ex_mem_bubble, md_timeout};
    check(tag, 32'(got), 32'(exp_q.pop_front()));
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic lu_m;
    reset = 1'b1;
    set_idle();
`ifdef PIPE_HAZARD_PERF_EN
    exp_stalls = 0; exp_flushes = 0;
`endif
    @(posedge clock); #1;
    // While reset is high, the md op and the hazard inputs must be ignored.
    ex_md_op = 1'b1;
    set_load(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    expect_cycle("reset_forced", RUN, C_FREE);
    set_idle();
    expect_cycle("reset_idle", RUN, C_FREE);
    reset = 1'b0;

    expect_cycle("idle", RUN, C_FREE);

    // Load-use on rs1: exactly one stall cycle.
    set_load(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    expect_cycle("lu_rs1_stall", RUN, C_LU);
    set_idle();
    expect_cycle("lu_rs1_after", RUN, C_FREE);

    // A load to x0 never stalls.
    set_load(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    expect_cycle("lu_x0", RUN, C_FREE);

    // Match on rs2 only when that operand is used.
    set_load(5'd9, 5'd1, 5'd9, 1'b1, 1'b1);
    expect_cycle("lu_rs2_stall", RUN, C_LU);
    set_load(5'd9, 5'd9, 5'd9, 1'b0, 1'b0);
    expect_cycle("lu_unused", RUN, C_FREE);

    // A taken branch wins over a load-use hit.
    set_load(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    expect_cycle("branch_lu", RUN, C_BRANCH);
    set_idle();
    expect_cycle("branch_after", RUN, C_FREE);

    // md_done while in RUN is ignored.
    md_done = 1'b1;
    expect_cycle("stray_done", RUN, C_FREE);
    md_done = 1'b0;

    // mul/div with md_done arriving 3 cycles after md_start.
    ex_md_op = 1'b1;
    expect_cycle("md_start", RUN, C_MDSTRT);
    expect_cycle("md_wait0", MD_WAIT, C_FREEZE);
    expect_cycle("md_wait1", MD_WAIT, C_FREEZE);
    md_done = 1'b1;
    expect_cycle("md_wait2_done", MD_WAIT, C_FREEZE);
    md_done = 1'b0;
    expect_cycle("md_done_state", MD_DONE, C_FREE);
    ex_md_op = 1'b0;
    expect_cycle("md_back_run", RUN, C_FREE);

    // Shortest op: md_done in the first wait cycle, then a load-use hit in MD_DONE.
    ex_md_op = 1'b1;
    expect_cycle("min_start", RUN, C_MDSTRT);
    md_done = 1'b1;
    expect_cycle("min_wait", MD_WAIT, C_FREEZE);
    md_done = 1'b0;
    set_load(5'd7, 5'd0, 5'd7, 1'b0, 1'b1);
    expect_cycle("min_done_lu", MD_DONE, C_LU);
    set_idle();
    expect_cycle("min_run", RUN, C_FREE);

    // md_done on the final count cycle: md_done wins and no error is flagged.
    ex_md_op = 1'b1;
    expect_cycle("edge_start", RUN, C_MDSTRT);
    for (int i = 0; i < TO; i++) begin
      md_done = (i == TO - 1);
      expect_cycle($sformatf("edge_wait%0d", i), MD_WAIT, C_FREEZE);
    end
    md_done = 1'b0;
    expect_cycle("edge_done", MD_DONE, C_FREE);
    ex_md_op = 1'b0;
    expect_cycle("edge_run", RUN, C_FREE);

    // md_done never arrives: forced release and a sticky error.
    ex_md_op = 1'b1;
    expect_cycle("to_start", RUN, C_MDSTRT);
    for (int i = 0; i < TO; i++)
      expect_cycle($sformatf("to_wait%0d", i), MD_WAIT, C_FREEZE);
    expect_cycle("to_done", MD_DONE, C_FREE | 8'h01);
    ex_md_op = 1'b0;
    for (int i = 0; i < 3; i++)
      expect_cycle($sformatf("to_sticky%0d", i), RUN, C_FREE | 8'h01);

`ifdef PIPE_HAZARD_PERF_EN
    @(negedge clock);
    check("perf_stalls", perf_stall_cycles, 32'(exp_stalls));
    check("perf_flushes", perf_flushes, 32'(exp_flushes));
    @(posedge clock); #1;
`endif

    // Only reset clears the error.
    reset = 1'b1;
    expect_cycle("to_reset", RUN, C_FREE);
    reset = 1'b0;
    expect_cycle("to_cleared", RUN, C_FREE);

    // Reset two cycles into MD_WAIT aborts the wait.
    ex_md_op = 1'b1;
    expect_cycle("abort_start", RUN, C_MDSTRT);
    expect_cycle("abort_wait0", MD_WAIT, C_FREEZE);
    expect_cycle("abort_wait1", MD_WAIT, C_FREEZE);
    reset = 1'b1;
    expect_cycle("abort_reset", MD_WAIT, C_FREE);
    reset = 1'b0;
    ex_md_op = 1'b0;
    md_done = 1'b1;
    expect_cycle("abort_late_done", RUN, C_FREE);
    md_done = 1'b0;
    expect_cycle("abort_run", RUN, C_FREE);

    // Random load-use patterns on a small register range to get frequent hits.
    for (int i = 0; i < 24; i++) begin
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      lu_m = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      expect_cycle($sformatf("rand%0d", i), RUN, lu_m ? C_LU : C_FREE);
    end
    set_idle();

`ifdef PIPE_HAZARD_PERF_EN
    @(negedge clock);
    check("perf_stalls_end", perf_stall_cycles, 32'(exp_stalls));
    check("perf_flushes_end", perf_flushes, 32'(exp_flushes));
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Time limit, so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
